// File: rtl/irq_aggregator.sv
// Avalon-MM interrupt aggregator: synchronizes raw irq lines, captures level/edge
// pending state, masks to one registered CPU irq, and keeps saturating event counters.
module irq_aggregator #(
    parameter int NUM_SRC = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               chipselect,
    input  logic [2:0]         address,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               irq
);

    logic [NUM_SRC-1:0] s1_q, s2_q, prev_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, edge_sel_q;
    logic [3:0]         count_sel_q;
    logic               ctrl_q;
    logic [CNT_W-1:0]   cnt_q [NUM_SRC];
    logic [CNT_W-1:0]   cnt_d [NUM_SRC];
    logic [15:0]        readdata_q, readdata_d;
    logic               irq_q, irq_d;

    logic               wr_en;
    logic [NUM_SRC-1:0] evt, pm, w1c, mode_chg;
    logic [3:0]         act_id;

    // Upper writedata bits are don't-care when NUM_SRC < 16.
    logic unused_wd;
    assign unused_wd = ^writedata;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        wr_en    = chipselect & ~write_n;
        evt      = s2_q & ~prev_q;
        pm       = pending_q & mask_q;
        w1c      = (wr_en && address == 3'd0) ? writedata[NUM_SRC-1:0] : '0;
        mode_chg = (wr_en && address == 3'd2) ? (writedata[NUM_SRC-1:0] ^ edge_sel_q) : '0;

        // Event beats W1C; a mode switch clears the bit outright.
        pending_d = ((edge_sel_q & (evt | (pending_q & ~w1c))) | (~edge_sel_q & s2_q))
                    & ~mode_chg;

        irq_d = ctrl_q & (|pm);

        act_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pm[i]) act_id = 4'(i);
        end

        for (int i = 0; i < NUM_SRC; i++) begin
            if (wr_en && address == 3'd5 && count_sel_q == 4'(i))
                cnt_d[i] = evt[i] ? CNT_W'(1) : '0;
            else if (evt[i])
                cnt_d[i] = sat_inc(cnt_q[i]);
            else
                cnt_d[i] = cnt_q[i];
        end

        readdata_d = '0;
        case (address)
            3'd0: readdata_d[NUM_SRC-1:0] = pending_q;
            3'd1: readdata_d[NUM_SRC-1:0] = mask_q;
            3'd2: readdata_d[NUM_SRC-1:0] = edge_sel_q;
            3'd3: begin
                readdata_d[15]  = |pm;
                readdata_d[3:0] = act_id;
            end
            3'd4: readdata_d[3:0] = count_sel_q;
            3'd5: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (count_sel_q == 4'(i)) readdata_d[CNT_W-1:0] = cnt_q[i];
                end
            end
            3'd6: readdata_d[0] = ctrl_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q        <= '0;
            s2_q        <= '0;
            prev_q      <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            edge_sel_q  <= '0;
            count_sel_q <= '0;
            ctrl_q      <= 1'b0;
            readdata_q  <= '0;
            irq_q       <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
        end else begin
            s1_q       <= irq_src;
            s2_q       <= s1_q;
            prev_q     <= s2_q;
            pending_q  <= pending_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= cnt_d[i];
            if (wr_en) begin
                case (address)
                    3'd1: mask_q      <= writedata[NUM_SRC-1:0];
                    3'd2: edge_sel_q  <= writedata[NUM_SRC-1:0];
                    3'd4: count_sel_q <= writedata[3:0];
                    3'd6: ctrl_q      <= writedata[0];
                    default: ;
                endcase
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_irq_aggregator.sv
// Randomized and directed bench for irq_aggregator (NUM_SRC=8, CNT_W=4) against a
// sample-history reference model of pending state, counters and the register map.
module tb_irq_aggregator;

    localparam int N    = 8;
    localparam int CMAX = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0;
    logic [2:0]  address = '0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic [N-1:0] irq_src = '0;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    irq_aggregator #(.NUM_SRC(N), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq_src(irq_src), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: hist[0] is the newest clock-edge sample of irq_src.
    logic [N-1:0] hist [3];
    logic [N-1:0] m_pend = '0, m_mask = '0, m_edge = '0;
    logic [3:0]   m_csel = '0;
    logic         m_ctrl = 1'b0;
    int           m_cnt [N];
    logic         m_irq = 1'b0;
    logic [15:0]  m_rd = '0;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) hist[i] = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_pend = '0; m_mask = '0; m_edge = '0; m_csel = '0; m_ctrl = 1'b0;
        m_irq = 1'b0; m_rd = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] ev, pm, np;
        logic         wr, found;
        int           id;
        wr = chipselect && !write_n;
        ev = hist[1] & ~hist[2];
        pm = m_pend & m_mask;
        m_irq = m_ctrl && (pm != 0);
        id = 0; found = 1'b0;
        for (int i = 0; i < N; i++) if (!found && pm[i]) begin id = i; found = 1'b1; end
        case (address)
            3'd0: m_rd = 16'(m_pend);
            3'd1: m_rd = 16'(m_mask);
            3'd2: m_rd = 16'(m_edge);
            3'd3: m_rd = found ? 16'(16'h8000 + id) : 16'h0000;
            3'd4: m_rd = 16'(m_csel);
            3'd5: m_rd = (int'(m_csel) < N) ? 16'(m_cnt[m_csel]) : 16'h0000;
            3'd6: m_rd = 16'(m_ctrl);
            default: m_rd = 16'h0000;
        endcase
        for (int i = 0; i < N; i++) begin
            if (wr && address == 3'd2 && writedata[i] != m_edge[i]) np[i] = 1'b0;
            else if (m_edge[i]) np[i] = ev[i] || (m_pend[i] && !(wr && address == 3'd0 && writedata[i]));
            else np[i] = hist[1][i];
            if (wr && address == 3'd5 && int'(m_csel) == i) m_cnt[i] = ev[i] ? 1 : 0;
            else if (ev[i] && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
        end
        m_pend = np;
        if (wr) begin
            case (address)
                3'd1: m_mask = writedata[N-1:0];
                3'd2: m_edge = writedata[N-1:0];
                3'd4: m_csel = writedata[3:0];
                3'd6: m_ctrl = writedata[0];
                default: ;
            endcase
        end
        hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = irq_src;
    endtask

    initial model_reset();

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        chk("mon_irq", 16'(irq), 16'(m_irq));
        chk("mon_rdata", readdata, m_rd);
    end

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input string tag, input logic [15:0] exp);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0;
        chk(tag, readdata, exp);
    endtask

    task automatic pulse(input logic [N-1:0] bits);
        irq_src = irq_src | bits;
        @(negedge clk);
        irq_src = irq_src & ~bits;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_irq", 16'(irq), 16'h0000);
        chk("reset_rdata", readdata, 16'h0000);
        reset_n = 1'b1;
        @(negedge clk);

        // Level path
        wr(3'd1, 16'h0001);
        wr(3'd6, 16'h0001);
        irq_src[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("lvl_irq_pre", 16'(irq), 16'h0000);
        @(negedge clk);
        chk("lvl_irq_on", 16'(irq), 16'h0001);
        rd(3'd0, "lvl_pending", 16'h0001);
        irq_src[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("lvl_irq_hold", 16'(irq), 16'h0001);
        @(negedge clk);
        chk("lvl_irq_off", 16'(irq), 16'h0000);

        // Edge path and W1C
        wr(3'd2, 16'h0004);
        wr(3'd1, 16'h0004);
        pulse(8'h04);
        repeat (4) @(negedge clk);
        rd(3'd0, "edge_pending", 16'h0004);
        chk("edge_irq", 16'(irq), 16'h0001);
        wr(3'd0, 16'h0004);
        @(negedge clk);
        chk("w1c_irq", 16'(irq), 16'h0000);
        rd(3'd0, "w1c_pending", 16'h0000);

        // W1C landing on the same edge as the event
        pulse(8'h04);
        @(negedge clk);
        wr(3'd0, 16'h0004);
        rd(3'd0, "collide_pending", 16'h0004);

        // Priority
        wr(3'd2, 16'h000E);
        wr(3'd1, 16'h000A);
        pulse(8'h0A);
        repeat (4) @(negedge clk);
        rd(3'd3, "prio_id", 16'h8001);
        wr(3'd1, 16'h0000);
        rd(3'd3, "prio_nomask", 16'h0000);
        chk("prio_nomask_irq", 16'(irq), 16'h0000);
        wr(3'd6, 16'h0000);
        wr(3'd1, 16'h000A);
        @(negedge clk);
        chk("prio_noctrl_irq", 16'(irq), 16'h0000);
        rd(3'd3, "prio_noctrl_id", 16'h8001);
        wr(3'd6, 16'h0001);

        // Counter saturation and clear
        for (int p = 0; p < 20; p++) begin
            pulse(8'h08);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        wr(3'd4, 16'h0003);
        rd(3'd5, "cnt_sat", 16'h000F);
        wr(3'd5, 16'h0000);
        rd(3'd5, "cnt_clr", 16'h0000);
        pulse(8'h08);
        @(negedge clk);
        wr(3'd5, 16'h0000);
        rd(3'd5, "cnt_clr_evt", 16'h0001);
        wr(3'd4, 16'h0009);
        rd(3'd5, "cnt_sel_oob", 16'h0000);
        wr(3'd5, 16'h0000);
        wr(3'd4, 16'h0003);
        rd(3'd5, "cnt_oob_clr", 16'h0001);

        // Reset mid-operation with irq_src[0] held high
        chk("pre_rst_irq", 16'(irq), 16'h0001);
        irq_src[0] = 1'b1;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_irq", 16'(irq), 16'h0000);
        chk("rst_async_rdata", readdata, 16'h0000);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        rd(3'd5, "rst_cnt0", 16'h0001);
        rd(3'd1, "rst_mask", 16'h0000);
        rd(3'd6, "rst_ctrl", 16'h0000);
        repeat (5) @(negedge clk);
        rd(3'd5, "rst_cnt0_once", 16'h0001);
        irq_src[0] = 1'b0;

        // Random traffic, checked cycle by cycle by the monitor
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) irq_src = irq_src ^ N'($urandom);
            chipselect = ($urandom_range(0, 2) == 0);
            write_n    = ($urandom_range(0, 1) == 0);
            address    = 3'($urandom);
            writedata  = 16'($urandom);
            @(negedge clk);
        end
        chipselect = 1'b0;
        write_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
